// File: rtl/toggle_rx_if.sv
// Event-link bundle between a toggle receiver (slave) and its driver/consumer (master).
interface toggle_rx_if #(parameter int CNT_W = 4);
  logic             t_in;
  logic             ev_valid;
  logic             ev_ready;
  logic [CNT_W-1:0] pending;
  logic             ack_t;
  logic             overflow;
  logic             ovf_clr;
  logic [15:0]      ev_total;

  modport master (
    output t_in, ev_ready, ovf_clr,
    input  ev_valid, pending, ack_t, overflow, ev_total
  );

  modport slave (
    input  t_in, ev_ready, ovf_clr,
    output ev_valid, pending, ack_t, overflow, ev_total
  );
endinterface

// File: rtl/toggle_rx.sv
// Toggle-encoded event receiver: synchronises t_in, turns each flip into one
// event, buffers events in a saturating counter and acks each consumed one.
module toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  toggle_rx_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam int WC_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'(SYNC_STAGES - 1);

  typedef enum logic {WARM, RUN} state_t;

  state_t                 r_state;
  logic [WC_W-1:0]        r_warm;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_pending;
  logic                   r_valid;
  logic                   r_ack;
  logic                   r_ovf;
  logic [15:0]            r_total;

  logic             w_t_sync;
  logic             w_edge;
  logic             w_take;
  logic             w_drop;
  logic             w_acc;
  logic [CNT_W-1:0] w_pend_nxt;

  assign w_t_sync = r_sync[SYNC_STAGES-1];
  assign w_edge   = (r_state == RUN) && (w_t_sync ^ r_prev);
  assign w_take   = r_valid && bus.ev_ready;
  // A same-cycle consume frees the slot, so a full counter only drops when idle.
  assign w_drop   = w_edge && !w_take && (r_pending == MAX);
  assign w_acc    = w_edge && !w_drop;

  always_comb begin
    w_pend_nxt = r_pending;
    if (w_acc && !w_take)
      w_pend_nxt = r_pending + 1'b1;
    else if (w_take && !w_edge)
      w_pend_nxt = r_pending - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WARM;
      r_warm    <= '0;
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_ack     <= 1'b0;
      r_ovf     <= 1'b0;
      r_total   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.t_in};
      case (r_state)
        WARM: begin
          if (r_warm == WARM_LAST) begin
            // Seed with the value the last stage is loading now, so a static
            // level present at release never reads as a flip.
            r_prev  <= r_sync[SYNC_STAGES-2];
            r_state <= RUN;
          end else begin
            r_warm <= r_warm + 1'b1;
          end
        end
        RUN: r_prev <= w_t_sync;
        default: r_state <= WARM;
      endcase

      r_pending <= w_pend_nxt;
      r_valid   <= (w_pend_nxt != '0);
      if (w_take) r_ack <= ~r_ack;
      if (w_acc)  r_total <= r_total + 16'd1;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (bus.ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign bus.ev_valid = r_valid;
  assign bus.pending  = r_pending;
  assign bus.ack_t    = r_ack;
  assign bus.overflow = r_ovf;
  assign bus.ev_total = r_total;

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx: a per-cycle vector table plus hand-written
// sequences for start-up, saturation, steady flow, reset and counter wrap.
module tb_toggle_rx;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  toggle_rx_if #(.CNT_W(4)) bus ();

  toggle_rx #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        t;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [3:0]  pend;
    logic        ack;
    logic        ovf;
    logic [15:0] tot;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic tlev);
    bus.t_in     = tlev;
    bus.ev_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    rst_n        = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int toggles;
    logic prev_ack;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    bus.t_in = 1'b0;
    bus.ev_ready = 1'b0;
    bus.ovf_clr = 1'b0;

    //          t  rdy clr  ev pend ack ovf tot
    vec[0]  = '{1, 0, 0,   0, 0,  0, 0, 0};
    vec[1]  = '{1, 0, 0,   0, 0,  0, 0, 0};
    vec[2]  = '{1, 0, 0,   1, 1,  0, 0, 1};
    vec[3]  = '{1, 1, 0,   0, 0,  1, 0, 1};
    vec[4]  = '{0, 1, 0,   0, 0,  1, 0, 1};
    vec[5]  = '{0, 1, 0,   0, 0,  1, 0, 1};
    vec[6]  = '{0, 0, 0,   1, 1,  1, 0, 2};
    vec[7]  = '{1, 0, 0,   1, 1,  1, 0, 2};
    vec[8]  = '{1, 0, 0,   1, 1,  1, 0, 2};
    vec[9]  = '{1, 1, 0,   1, 1,  0, 0, 3};
    vec[10] = '{1, 1, 0,   0, 0,  1, 0, 3};
    vec[11] = '{1, 0, 1,   0, 0,  1, 0, 3};

    // static-high level through reset release produces no event
    do_reset(1'b1);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_valid", int'(bus.ev_valid), 0);
    chk("rst_ack", int'(bus.ack_t), 0);
    for (int i = 0; i < 20; i++) step();
    chk("static_pending", int'(bus.pending), 0);
    chk("static_valid", int'(bus.ev_valid), 0);
    chk("static_total", int'(bus.ev_total), 0);

    // per-cycle table: latency, consume, edge+consume collision, idle ready
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 12; i++) begin
      bus.t_in     = vec[i].t;
      bus.ev_ready = vec[i].rdy;
      bus.ovf_clr  = vec[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), int'(bus.ev_valid), int'(vec[i].ev));
      chk($sformatf("vec%0d_pending", i), int'(bus.pending), int'(vec[i].pend));
      chk($sformatf("vec%0d_ack", i), int'(bus.ack_t), int'(vec[i].ack));
      chk($sformatf("vec%0d_ovf", i), int'(bus.overflow), int'(vec[i].ovf));
      chk($sformatf("vec%0d_total", i), int'(bus.ev_total), int'(vec[i].tot));
    end
    bus.ovf_clr = 1'b0;

    // 17 flips into a 15-deep counter
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 17; i++) begin
      bus.t_in = ~bus.t_in;
      step();
      step();
    end
    for (int i = 0; i < 4; i++) step();
    chk("full_pending", int'(bus.pending), 15);
    chk("full_ovf", int'(bus.overflow), 1);
    chk("full_total", int'(bus.ev_total), 15);
    chk("full_valid", int'(bus.ev_valid), 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", int'(bus.overflow), 0);
    chk("ovf_clr_pending", int'(bus.pending), 15);

    // at full, one consume per flip: counter rides 14..15 without dropping
    toggles = 0;
    prev_ack = bus.ack_t;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        bus.t_in = ~bus.t_in;
        bus.ev_ready = 1'b0;
      end else begin
        bus.ev_ready = 1'b1;
      end
      step();
      if (bus.pending < 4'd14) chk("flow_pending_low", int'(bus.pending), 14);
      if (bus.overflow) chk("flow_ovf", int'(bus.overflow), 0);
      if (bus.ack_t != prev_ack) toggles++;
      prev_ack = bus.ack_t;
    end
    bus.ev_ready = 1'b0;
    step();
    chk("flow_toggles", toggles, 10);
    chk("flow_end_pending", int'(bus.pending), 15);
    chk("flow_end_total", int'(bus.ev_total), 25);
    chk("flow_end_ovf", int'(bus.overflow), 0);

    // asynchronous reset with events pending and ack toggled
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 6; i++) begin
      bus.t_in = ~bus.t_in;
      step();
      step();
    end
    for (int i = 0; i < 3; i++) step();
    bus.ev_ready = 1'b1;
    step();
    bus.ev_ready = 1'b0;
    chk("pre_rst_pending", int'(bus.pending), 5);
    chk("pre_rst_ack", int'(bus.ack_t), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_pending", int'(bus.pending), 0);
    chk("async_valid", int'(bus.ev_valid), 0);
    chk("async_ack", int'(bus.ack_t), 0);
    chk("async_total", int'(bus.ev_total), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("warm_valid", int'(bus.ev_valid), 0);
    bus.t_in = ~bus.t_in;
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_pending", int'(bus.pending), 1);
    chk("post_rst_total", int'(bus.ev_total), 1);
    chk("post_rst_ack", int'(bus.ack_t), 0);

    // 65537 events consumed back-to-back wrap the 16-bit total to 1
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    bus.ev_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.t_in = ~bus.t_in;
      step();
    end
    for (int i = 0; i < 5; i++) step();
    chk("wrap_total", int'(bus.ev_total), 1);
    chk("wrap_pending", int'(bus.pending), 0);
    chk("wrap_ack", int'(bus.ack_t), 1);
    chk("wrap_ovf", int'(bus.overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
